// File: rtl/reg_intf_dw_down.sv
// reg_intf_dw_down: splits 64-bit register-bus requests into one or two 32-bit
// downstream beats and reassembles the 64-bit response.
package reg_intf_dw_down_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic        valid;
    } reg_intf_req_a32_d64;

    typedef struct packed {
        logic [63:0] rdata;
        logic        error;
        logic        ready;
    } reg_intf_resp_d64;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_intf_req_a32_d32;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_intf_resp_d32;
endpackage

module reg_intf_dw_down
    import reg_intf_dw_down_pkg::*;
#(
    parameter bit ErrorAbort = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  reg_intf_req_a32_d64 up_req_i,
    output reg_intf_resp_d64    up_rsp_o,
    output reg_intf_req_a32_d32 dn_req_o,
    input  reg_intf_resp_d32    dn_rsp_i
);
    typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  wstrb_q, wstrb_d;
    logic        hi_q, hi_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        beat_err;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        hi_d     = hi_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        beat_err = err_q | dn_rsp_i.error;
        case (state_q)
            IDLE: if (up_req_i.valid) begin
                addr_d  = up_req_i.addr & 32'hFFFF_FFF8;
                write_d = up_req_i.write;
                wdata_d = up_req_i.wdata;
                wstrb_d = up_req_i.wstrb;
                hi_d    = !up_req_i.write || (up_req_i.wstrb[7:4] != 4'h0);
                rdata_d = '0;
                err_d   = 1'b0;
                // a write touching only the upper word skips the low beat
                state_d = (up_req_i.write && up_req_i.wstrb[3:0] == 4'h0 &&
                           up_req_i.wstrb[7:4] != 4'h0) ? HI : LO;
            end
            LO: if (dn_rsp_i.ready) begin
                if (!write_q) rdata_d[31:0] = dn_rsp_i.rdata;
                err_d   = beat_err;
                state_d = (hi_q && !(ErrorAbort && beat_err)) ? HI : RESP;
            end
            HI: if (dn_rsp_i.ready) begin
                if (!write_q) rdata_d[63:32] = dn_rsp_i.rdata;
                err_d   = beat_err;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dn_req_o = '0;
        up_rsp_o = '0;
        if (state_q == LO || state_q == HI) begin
            dn_req_o.addr  = addr_q | {29'b0, state_q == HI, 2'b00};
            dn_req_o.write = write_q;
            dn_req_o.wdata = (state_q == HI) ? wdata_q[63:32] : wdata_q[31:0];
            dn_req_o.wstrb = (state_q == HI) ? wstrb_q[7:4] : wstrb_q[3:0];
            dn_req_o.valid = 1'b1;
        end
        if (state_q == RESP) begin
            up_rsp_o.rdata = rdata_q;
            up_rsp_o.error = err_q;
            up_rsp_o.ready = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            hi_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            hi_q    <= hi_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_reg_intf_dw_down.sv
// tb_reg_intf_dw_down: drives both ErrorAbort variants against a wait-state
// slave and checks responses and beats against a transaction-level model.
module tb_reg_intf_dw_down;
    import reg_intf_dw_down_pkg::*;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } beat_t;

    typedef struct {
        int          sel;
        logic [31:0] a;
        logic        wr;
        logic [63:0] wd;
        logic [7:0]  ws;
        int          w;
        logic        el;
        logic        eh;
        logic [63:0] xrd;
        logic        xer;
        int          xlat;
        int          xnb;
        logic [31:0] xa0;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_intf_req_a32_d64 up_req[2];
    reg_intf_resp_d64    up_rsp[2];
    reg_intf_req_a32_d32 dn_req[2];
    reg_intf_resp_d32    dn_rsp[2];

    int    checks = 0;
    int    errors = 0;
    int    waits = 0;
    logic  err_lo = 1'b0;
    logic  err_hi = 1'b0;
    int    cnt[2];
    int    bcnt[2] = '{0, 0};
    beat_t blog[2][8];

    reg_intf_dw_down #(.ErrorAbort(1'b1)) u_abort (
        .clk_i(clk), .rst_ni(rst_n),
        .up_req_i(up_req[0]), .up_rsp_o(up_rsp[0]),
        .dn_req_o(dn_req[0]), .dn_rsp_i(dn_rsp[0])
    );

    reg_intf_dw_down #(.ErrorAbort(1'b0)) u_cont (
        .clk_i(clk), .rst_ni(rst_n),
        .up_req_i(up_req[1]), .up_rsp_o(up_rsp[1]),
        .dn_req_o(dn_req[1]), .dn_rsp_i(dn_rsp[1])
    );

    function automatic logic [31:0] slave_data(input logic [31:0] a);
        if (a == 32'h1000_0008) return 32'hAAAA_0001;
        if (a == 32'h1000_000C) return 32'hBBBB_0002;
        return {a[15:0] ^ 16'h5A5A, ~a[31:16]};
    endfunction

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            dn_rsp[i].ready = dn_req[i].valid && (cnt[i] == waits);
            dn_rsp[i].rdata = dn_req[i].valid ? slave_data(dn_req[i].addr) : 32'h0;
            dn_rsp[i].error = dn_rsp[i].ready && (dn_req[i].addr[2] ? err_hi : err_lo);
        end
    end

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) cnt[i] <= 0;
            else if (dn_req[i].valid) cnt[i] <= dn_rsp[i].ready ? 0 : cnt[i] + 1;
            else cnt[i] <= 0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (dn_req[i].valid && dn_rsp[i].ready) begin
                blog[i][bcnt[i] % 8] <= '{dn_req[i].addr, dn_req[i].write, dn_req[i].wdata, dn_req[i].wstrb};
                bcnt[i] <= bcnt[i] + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // A 64-bit access becomes the low word then the high word at base and base+4.
    task automatic model(input logic abort, input logic [31:0] a, input logic wr,
                         input logic [63:0] wd, input logic [7:0] ws, input logic el,
                         input logic eh, output beat_t b[2], output int n,
                         output logic [63:0] rd, output logic er);
        logic [31:0] base;
        bit lo, hi;
        base = {a[31:3], 3'b000};
        lo = !wr || ws[3:0] != 4'h0 || ws == 8'h00;
        hi = !wr || ws[7:4] != 4'h0;
        n = 0; rd = '0; er = 1'b0;
        b[0] = '0; b[1] = '0;
        if (lo) begin
            b[n] = '{base, wr, wd[31:0], ws[3:0]};
            n++;
            er = el;
            if (!wr) rd[31:0] = slave_data(base);
        end
        if (hi && !(abort && lo && el)) begin
            b[n] = '{base + 32'd4, wr, wd[63:32], ws[7:4]};
            n++;
            er = er | eh;
            if (!wr) rd[63:32] = slave_data(base + 32'd4);
        end
    endtask

    task automatic run(input int sel, input logic [31:0] a, input logic wr, input logic [63:0] wd,
                       input logic [7:0] ws, input int w, input logic el, input logic eh,
                       output int lat, output logic [63:0] rd, output logic er,
                       output int nb, output logic [31:0] a0);
        int s, mnb;
        reg_intf_req_a32_d32 prev;
        logic pv, pr, mer;
        logic [63:0] mrd;
        beat_t mb[2];
        waits = w; err_lo = el; err_hi = eh;
        s = bcnt[sel];
        up_req[sel] = '{a, wr, wd, ws, 1'b1};
        lat = 0; pv = 1'b0; pr = 1'b0; prev = '0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (pv && !pr && dn_req[sel].valid) chk("dn_stable", dn_req[sel], prev);
            pv = dn_req[sel].valid; pr = dn_rsp[sel].ready; prev = dn_req[sel];
        end while (!up_rsp[sel].ready && lat < 60);
        chk("rsp_ready", up_rsp[sel].ready, 1);
        chk("no_overlap", dn_req[sel].valid, 0);
        rd = up_rsp[sel].rdata;
        er = up_rsp[sel].error;
        up_req[sel] = '0;
        @(posedge clk); #1;
        chk("rsp_single_cycle", up_rsp[sel].ready, 0);
        nb = bcnt[sel] - s;
        a0 = blog[sel][s % 8].addr;
        model(sel == 0, a, wr, wd, ws, el, eh, mb, mnb, mrd, mer);
        chk("m_nbeats", nb, mnb);
        chk("m_rdata", rd, mrd);
        chk("m_error", er, mer);
        chk("m_latency", lat, 1 + mnb * (w + 1));
        for (int j = 0; j < mnb && j < nb; j++) chk("m_beat", blog[sel][(s + j) % 8], mb[j]);
    endtask

    vec_t vt[10];
    int lat, nb;
    logic [63:0] rd;
    logic er;
    logic [31:0] a0;

    initial begin
        vt[0] = '{0, 32'h1000_0008, 1'b0, 64'h0, 8'h00, 0, 1'b0, 1'b0, 64'hBBBB_0002_AAAA_0001, 1'b0, 3, 2, 32'h1000_0008};
        vt[1] = '{0, 32'h1000_0008, 1'b1, 64'h1122_3344_5566_7788, 8'hF0, 0, 1'b0, 1'b0, 64'h0, 1'b0, 2, 1, 32'h1000_000C};
        vt[2] = '{1, 32'h2000_0010, 1'b1, 64'h1122_3344_5566_7788, 8'h00, 0, 1'b0, 1'b0, 64'h0, 1'b0, 2, 1, 32'h2000_0010};
        vt[3] = '{0, 32'h1000_0008, 1'b1, 64'h1122_3344_5566_7788, 8'hFF, 0, 1'b0, 1'b0, 64'h0, 1'b0, 3, 2, 32'h1000_0008};
        vt[4] = '{0, 32'h1000_000F, 1'b0, 64'h0, 8'h00, 3, 1'b0, 1'b0, 64'hBBBB_0002_AAAA_0001, 1'b0, 9, 2, 32'h1000_0008};
        vt[5] = '{0, 32'h1000_0008, 1'b0, 64'h0, 8'h00, 0, 1'b1, 1'b0, 64'h0000_0000_AAAA_0001, 1'b1, 2, 1, 32'h1000_0008};
        vt[6] = '{1, 32'h1000_0008, 1'b0, 64'h0, 8'h00, 0, 1'b1, 1'b0, 64'hBBBB_0002_AAAA_0001, 1'b1, 3, 2, 32'h1000_0008};
        vt[7] = '{0, 32'h1000_0008, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F, 1, 1'b1, 1'b0, 64'h0, 1'b1, 3, 1, 32'h1000_0008};
        vt[8] = '{0, 32'h1000_0008, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 0, 1'b1, 1'b0, 64'h0, 1'b1, 2, 1, 32'h1000_0008};
        vt[9] = '{0, 32'h1000_0008, 1'b0, 64'h0, 8'h00, 0, 1'b0, 1'b1, 64'hBBBB_0002_AAAA_0001, 1'b1, 3, 2, 32'h1000_0008};
        up_req[0] = '0;
        up_req[1] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dn0", dn_req[0], 0);
        chk("rst_up0", up_rsp[0], 0);
        chk("rst_dn1", dn_req[1], 0);
        chk("rst_up1", up_rsp[1], 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vt[k]) begin
            run(vt[k].sel, vt[k].a, vt[k].wr, vt[k].wd, vt[k].ws, vt[k].w, vt[k].el, vt[k].eh, lat, rd, er, nb, a0);
            chk("t_rdata", rd, vt[k].xrd);
            chk("t_error", er, vt[k].xer);
            chk("t_latency", lat, vt[k].xlat);
            chk("t_nbeats", nb, vt[k].xnb);
            chk("t_addr0", a0, vt[k].xa0);
        end

        // reset asserted while the high beat is waiting on the slave
        waits = 2; err_lo = 1'b0; err_hi = 1'b0;
        up_req[0] = '{32'h1000_0008, 1'b0, 64'h0, 8'h00, 1'b1};
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!(dn_req[0].valid && dn_req[0].addr[2]) && lat < 20);
        chk("hi_reached", dn_req[0].valid && dn_req[0].addr[2], 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_dn", dn_req[0], 0);
        chk("rst_mid_up", up_rsp[0], 0);
        up_req[0] = '0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_idle_dn", dn_req[0], 0);
        run(0, 32'h1000_0008, 1'b0, 64'h0, 8'h00, 0, 1'b0, 1'b0, lat, rd, er, nb, a0);
        chk("post_rst_rdata", rd, 64'hBBBB_0002_AAAA_0001);
        chk("post_rst_lat", lat, 3);

        for (int k = 0; k < 40; k++) begin
            logic [7:0] ws;
            int pick;
            pick = $urandom_range(0, 3);
            ws = (pick == 0) ? 8'h00 : (pick == 1) ? 8'h0F : (pick == 2) ? 8'hF0 : 8'($urandom);
            run($urandom_range(0, 1), $urandom, 1'($urandom_range(0, 1)), {$urandom, $urandom}, ws,
                $urandom_range(0, 2), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                lat, rd, er, nb, a0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_intf_dw_down.md
# reg_intf_dw_down

Register-interface data-width downsizer: accepts 64-bit-data requests (`reg_intf_req_a32_d64` / `reg_intf_resp_d64`) from an upstream master and replays each as one or two 32-bit-data transactions (`reg_intf_req_a32_d32` / `reg_intf_resp_d32`) on a downstream port. It sits directly in front of 32-bit register files and peripherals on the 64-bit register bus. The read response is assembled from the 32-bit halves and returned to the master.

## Interface
- `ErrorAbort`, default 1: 1 = an error on the low beat suppresses the high beat; 0 = the high beat is still issued.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `up_req_i`  in  106 (`reg_intf_req_a32_d64`)  upstream request.
- `up_rsp_o`  out  66 (`reg_intf_resp_d64`)  upstream response.
- `dn_req_o`  out  70 (`reg_intf_req_a32_d32`)  downstream request.
- `dn_rsp_i`  in  34 (`reg_intf_resp_d32`)  downstream response.

## Operation
- FSM states: IDLE, LO, HI, RESP.
- IDLE, `up_req_i.valid`=1: latch addr, write, wdata, wstrb.
  - Plan the beats:
    - read: LO then HI.
    - write: LO if `wstrb[3:0]`≠0; HI if `wstrb[7:4]`≠0; if wstrb==0, LO only, with strobe 0.
  - Go to the first planned state.
  - Clear the captured rdata and the error accumulator.
- LO: `dn_req_o` = {addr[31:3], 3'b000}, write, wdata[31:0], wstrb[3:0], valid=1.
  - On `dn_rsp_i.ready`: capture `rdata[31:0]` (reads only) and OR in error.
  - Next state: HI if planned and not (ErrorAbort && error), else RESP.
- HI: same as LO, but addr = {addr[31:3], 3'b100}, data/strobe = upper halves, captured into `rdata[63:32]`.
  - Next state: RESP on `dn_rsp_i.ready`.
- RESP: `up_rsp_o.ready`=1 for exactly one cycle.
  - `rdata` = {hi, lo}; halves not read are 0; write responses return rdata 0.
  - `error` = accumulated OR.
  - Next state: IDLE.
- Upstream address bits [2:0] are ignored (the request is treated as 8-byte aligned).
- Downstream request fields are driven from registers only; `dn_req_o.valid` never depends on `dn_rsp_i.ready`. Fields are constant while valid is high.
- `dn_rsp_i` is ignored outside LO/HI.
- `up_req_i` is ignored outside IDLE. The master holds it stable until ready, per the protocol.

## Timing
- Reset (async assert, sync to clk on deassert) puts the FSM in IDLE and drives all outputs to 0: `dn_req_o`=0, `up_rsp_o`=0, captured rdata/error = 0.
- Reset mid-transaction aborts immediately; downstream valid drops in the same cycle.
- Cycle n: valid seen in IDLE. n+1: first downstream beat is valid.
- Each beat lasts 1 cycle plus downstream wait cycles.
- Minimum latency, valid to `up_rsp_o.ready`, with a zero-wait slave:
  - single beat: 2 cycles (n+2);
  - two beats: 3 cycles (n+3).
- The cycle after RESP is IDLE. A master keeping valid high for a new request is accepted there.
- Back-to-back throughput: 3 cycles per single-beat access, 4 cycles per two-beat access.
- `up_rsp_o.ready` never coincides with downstream valid.
- The state of `up_req_i.valid` during RESP has no effect.

## Test plan
- Read, addr 0x1000_0008, slave returns 0xAAAA_0001 at 0x1000_0008 and 0xBBBB_0002 at 0x1000_000C, zero wait:
  - expected: two beats (addr 0x1000_0008 then 0x1000_000C), then ready at n+3 with rdata 0xBBBB_0002_AAAA_0001, error 0.
- Write, wstrb 0xF0, wdata 0x1122_3344_5566_7788:
  - expected: single HI beat, addr base+4, wdata 0x1122_3344, wstrb 0xF, then ready at n+2.
- Write, wstrb 0x00:
  - expected: single LO beat with wstrb 0, then ready.
- Write, wstrb 0xFF:
  - expected: LO beat carries 0x5566_7788, HI beat carries 0x1122_3344, both with strobe 0xF.
- Read with a 3-wait-state slave on each beat:
  - expected: ready at n+9; downstream fields stable across all wait cycles.
- Read, LO beat returns error=1:
  - ErrorAbort=1: no HI beat; response error 1, rdata[63:32]=0.
  - ErrorAbort=0: HI beat issued; response error 1.
- Assert `rst_ni` during the HI beat:
  - expected: all outputs 0 immediately.
  - After release: FSM in IDLE, and the next read completes normally.
